intra_interp_pipe: RTL and testbench

Parametrised, pipelined two-tap fractional interpolator for the intra angular datapath. Each lane computes `((2^FRAC_BITS − f)·r0 + f·r1 + 2^(FRAC_BITS−1)) >> FRAC_BITS` using shift-add constant multiplication, with no hard multipliers. `LANES` samples are processed per beat behind a valid/ready handshake. The block sits between the reference-sample fetch and the prediction-block writer. It generalises the fixed two-constant multiplier blocks to a runtime-selectable weight, with elastic pipelining.

---
 rtl/intra_interp_pipe.sv | 124 ++++++++++++
 tb/tb_intra_interp_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra_interp_pipe.sv
// Three-stage elastic two-tap fractional interpolator:
// y = ((2^FRAC_BITS - f)*r0 + f*r1 + 2^(FRAC_BITS-1)) >> FRAC_BITS, built from shift-add products.
module intra_interp_pipe #(
  parameter int BIT_DEPTH = 8,
  parameter int LANES     = 4,
  parameter int FRAC_BITS = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FRAC_BITS-1:0]       in_frac,
  input  logic [LANES*BIT_DEPTH-1:0] in_ref0,
  input  logic [LANES*BIT_DEPTH-1:0] in_ref1,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*BIT_DEPTH-1:0] out_pred,
  output logic                       out_last
);

  localparam int DW = LANES * BIT_DEPTH;
  localparam int PW = BIT_DEPTH + FRAC_BITS + 1;
  localparam int SW = PW + 1;
  localparam logic [FRAC_BITS:0] FULL_W = (FRAC_BITS + 1)'(1) << FRAC_BITS;
  localparam logic [SW-1:0]      ROUND  = SW'(1) << (FRAC_BITS - 1);

  // Handshake: a beat moves across a port on any rising edge where valid && ready;
  // valid never depends on ready, and a stage loads whenever it is empty or its successor loads.
  logic r_v1, r_v2, r_v3;
  logic w_rdy1, w_rdy2, w_rdy3;

  assign w_rdy3   = out_ready || !r_v3;
  assign w_rdy2   = w_rdy3 || !r_v2;
  assign w_rdy1   = w_rdy2 || !r_v1;
  assign in_ready = w_rdy1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_rdy1) r_v1 <= in_valid;
      if (w_rdy2) r_v2 <= r_v1;
      if (w_rdy3) r_v3 <= r_v2;
    end
  end

  logic [FRAC_BITS-1:0] r1_f;
  logic [FRAC_BITS:0]   r1_g;
  logic [DW-1:0]        r1_ref0;
  logic [DW-1:0]        r1_ref1;
  logic                 r1_last;

  always_ff @(posedge clk) begin
    if (w_rdy1) begin
      r1_f    <= in_frac;
      r1_g    <= FULL_W - {1'b0, in_frac};
      r1_ref0 <= in_ref0;
      r1_ref1 <= in_ref1;
      r1_last <= in_last;
    end
  end

  logic [LANES-1:0][PW-1:0] w_p0;
  logic [LANES-1:0][PW-1:0] w_p1;

  always_comb begin
    w_p0 = '0;
    w_p1 = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k <= FRAC_BITS; k++) begin
        if (r1_g[k]) w_p0[l] = w_p0[l] + (PW'(r1_ref0[l*BIT_DEPTH +: BIT_DEPTH]) << k);
      end
      for (int k = 0; k < FRAC_BITS; k++) begin
        if (r1_f[k]) w_p1[l] = w_p1[l] + (PW'(r1_ref1[l*BIT_DEPTH +: BIT_DEPTH]) << k);
      end
    end
  end

  logic [LANES-1:0][PW-1:0] r2_p0;
  logic [LANES-1:0][PW-1:0] r2_p1;
  logic                     r2_last;

  always_ff @(posedge clk) begin
    if (w_rdy2) begin
      r2_p0   <= w_p0;
      r2_p1   <= w_p1;
      r2_last <= r1_last;
    end
  end

  // The weights sum to 2^FRAC_BITS, so the shifted result always fits BIT_DEPTH bits.
  logic [LANES-1:0][SW-1:0] w_sum;
  logic [DW-1:0]            w_y;
  logic                     w_unused_bits;

  always_comb begin
    w_sum         = '0;
    w_y           = '0;
    w_unused_bits = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_sum[l] = SW'(r2_p0[l]) + SW'(r2_p1[l]) + ROUND;
      w_y[l*BIT_DEPTH +: BIT_DEPTH] = w_sum[l][FRAC_BITS +: BIT_DEPTH];
      w_unused_bits = w_unused_bits ^ (^w_sum[l]);
    end
  end

  logic [DW-1:0] r3_pred;
  logic          r3_last;

  always_ff @(posedge clk) begin
    if (w_rdy3) begin
      r3_pred <= w_y;
      r3_last <= r2_last;
    end
  end

  assign out_valid = r_v3;
  assign out_pred  = r3_pred;
  assign out_last  = r3_last;

endmodule

// File: tb/tb_intra_interp_pipe.sv
// Bench for intra_interp_pipe: default instance (a_*) and a 10-bit/8-lane/6-frac instance (b_*).
module tb_intra_interp_pipe;

  localparam int BD   = 8;
  localparam int L    = 4;
  localparam int FB   = 5;
  localparam int DW   = BD * L;
  localparam int BD_B = 10;
  localparam int L_B  = 8;
  localparam int FB_B = 6;
  localparam int DW_B = BD_B * L_B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW:0]   exp_q[$];
  logic [DW_B:0] expb_q[$];

  logic            a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
  logic [FB-1:0]   a_in_frac;
  logic [DW-1:0]   a_ref0, a_ref1, a_out_pred;
  logic            b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
  logic [FB_B-1:0] b_in_frac;
  logic [DW_B-1:0] b_ref0, b_ref1, b_out_pred;

  intra_interp_pipe #(.BIT_DEPTH(BD), .LANES(L), .FRAC_BITS(FB)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_frac(a_in_frac),
    .in_ref0(a_ref0), .in_ref1(a_ref1), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pred(a_out_pred), .out_last(a_out_last)
  );

  intra_interp_pipe #(.BIT_DEPTH(BD_B), .LANES(L_B), .FRAC_BITS(FB_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_frac(b_in_frac),
    .in_ref0(b_ref0), .in_ref1(b_ref1), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pred(b_out_pred), .out_last(b_out_last)
  );

  // Reference: the interpolation formula in plain integer arithmetic.
  function automatic int interp(int r0, int r1, int f, int fb);
    return (((1 << fb) - f) * r0 + f * r1 + (1 << (fb - 1))) >> fb;
  endfunction

  function automatic logic [DW:0] model_a(logic last, logic [DW-1:0] r0, logic [DW-1:0] r1,
                                          logic [FB-1:0] f);
    logic [DW:0] v;
    v[DW] = last;
    for (int l = 0; l < L; l++)
      v[l*BD +: BD] = BD'(interp(int'(r0[l*BD +: BD]), int'(r1[l*BD +: BD]), int'(f), FB));
    return v;
  endfunction

  function automatic logic [DW_B:0] model_b(logic last, logic [DW_B-1:0] r0, logic [DW_B-1:0] r1,
                                            logic [FB_B-1:0] f);
    logic [DW_B:0] v;
    v[DW_B] = last;
    for (int l = 0; l < L_B; l++)
      v[l*BD_B +: BD_B] = BD_B'(interp(int'(r0[l*BD_B +: BD_B]), int'(r1[l*BD_B +: BD_B]),
                                       int'(f), FB_B));
    return v;
  endfunction

  task automatic rand_a();
    a_ref0    = $urandom();
    a_ref1    = $urandom();
    a_in_frac = FB'($urandom());
    a_in_last = 1'($urandom());
  endtask

  task automatic rand_b();
    b_ref0    = DW_B'({$urandom(), $urandom(), $urandom()});
    b_ref1    = DW_B'({$urandom(), $urandom(), $urandom()});
    b_in_frac = FB_B'($urandom());
    b_in_last = 1'($urandom());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; rand_a();
    b_in_valid = 1'b0; b_out_ready = 1'b0; rand_b();
    #3;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated beat with identical lanes; output must appear on the third edge
  // counting the accepting edge, and not before.
  task automatic test_single(input logic [BD-1:0] r0, input logic [BD-1:0] r1,
                             input logic [FB-1:0] f, input logic [BD-1:0] exp_y);
    logic lastv;
    @(negedge clk);
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    a_ref0 = {L{r0}}; a_ref1 = {L{r1}}; a_in_frac = f;
    a_in_last = 1'($urandom()); lastv = a_in_last;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL single_in_ready: got %b expected 1", a_in_ready);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== (c == 3)) begin
        errors++; $display("FAIL latency: edge %0d out_valid got %b expected %b", c, a_out_valid, c == 3);
      end
    end
    checks++;
    if (a_out_pred !== {L{exp_y}}) begin
      errors++; $display("FAIL single_pred f=%0d: got %h expected %h", f, a_out_pred, {L{exp_y}});
    end
    checks++;
    if (a_out_last !== lastv) begin
      errors++; $display("FAIL single_last: got %b expected %b", a_out_last, lastv);
    end
  endtask

  task automatic test_streaming();
    logic [DW:0] e;
    exp_q.delete();
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      a_in_valid = (cyc < 64);
      rand_a();
      #1;
      checks++;
      if (a_out_valid !== (cyc >= 3 && cyc <= 66)) begin
        errors++; $display("FAIL stream_valid: cycle %0d got %b expected %b", cyc, a_out_valid, cyc >= 3 && cyc <= 66);
      end
      if (a_in_valid && a_in_ready !== 1'b1) begin
        checks++; errors++; $display("FAIL stream_in_ready: cycle %0d got %b expected 1", cyc, a_in_ready);
      end
      if (a_out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: unexpected beat %h", a_out_pred);
        end else begin
          e = exp_q.pop_front();
          if ({a_out_last, a_out_pred} !== e) begin
            errors++; $display("FAIL stream_data: got %h expected %h", {a_out_last, a_out_pred}, e);
          end
        end
      end
      if (a_in_valid && a_in_ready) exp_q.push_back(model_a(a_in_last, a_ref0, a_ref1, a_in_frac));
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stream_drop: %0d beats missing expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [DW:0] e;
    int acc;
    exp_q.delete();
    acc = 0;
    a_out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      rand_a();
      #1;
      checks++;
      if (a_in_ready !== (cyc < 3)) begin
        errors++; $display("FAIL bp_in_ready: cycle %0d got %b expected %b", cyc, a_in_ready, cyc < 3);
      end
      if (a_out_valid && exp_q.size() != 0) begin
        checks++;
        if ({a_out_last, a_out_pred} !== exp_q[0]) begin
          errors++; $display("FAIL bp_stable: got %h expected %h", {a_out_last, a_out_pred}, exp_q[0]);
        end
      end
      if (a_in_valid && a_in_ready) begin
        acc++;
        exp_q.push_back(model_a(a_in_last, a_ref0, a_ref1, a_in_frac));
      end
    end
    checks++;
    if (acc != 3) begin
      errors++; $display("FAIL bp_accepted: got %0d expected 3", acc);
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      a_in_valid = (cyc == 0);
      a_out_ready = 1'b1;
      rand_a();
      #1;
      if (cyc == 0) begin
        checks++;
        if (a_in_ready !== 1'b1) begin
          errors++; $display("FAIL bp_release_ready: got %b expected 1", a_in_ready);
        end
      end
      if (a_out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: unexpected beat %h", a_out_pred);
        end else begin
          e = exp_q.pop_front();
          if ({a_out_last, a_out_pred} !== e) begin
            errors++; $display("FAIL bp_data: got %h expected %h", {a_out_last, a_out_pred}, e);
          end
        end
      end
      if (a_in_valid && a_in_ready) exp_q.push_back(model_a(a_in_last, a_ref0, a_ref1, a_in_frac));
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL bp_drop: %0d beats missing expected 0", exp_q.size());
    end
  endtask

  task automatic test_random_a(input int n);
    logic [DW:0] e;
    exp_q.delete();
    for (int cyc = 0; cyc < n + 20; cyc++) begin
      @(negedge clk);
      a_in_valid  = (cyc < n) && ($urandom_range(0, 3) != 0);
      a_out_ready = (cyc >= n) || ($urandom_range(0, 1) == 1);
      rand_a();
      #1;
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_a_extra: unexpected beat %h", a_out_pred);
        end else begin
          e = exp_q.pop_front();
          if ({a_out_last, a_out_pred} !== e) begin
            errors++; $display("FAIL rand_a_data: got %h expected %h", {a_out_last, a_out_pred}, e);
          end
        end
      end
      if (a_in_valid && a_in_ready) exp_q.push_back(model_a(a_in_last, a_ref0, a_ref1, a_in_frac));
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_a_drop: %0d beats missing expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      rand_a();
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b1) begin
      errors++; $display("FAIL rmid_loaded: got %b expected 1", a_out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_async_valid: got %b expected 0", a_out_valid);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_in_ready: got %b expected 1", a_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      #1;
      checks++;
      if (a_out_valid !== 1'b0) begin
        errors++; $display("FAIL rmid_empty: cycle %0d got %b expected 0", cyc, a_out_valid);
      end
    end
    test_single(8'd100, 8'd200, 5'd8, 8'd125);
  endtask

  task automatic test_sweep(input int n);
    logic [DW_B:0] e;
    @(negedge clk);
    b_in_valid = 1'b1; b_out_ready = 1'b1;
    b_ref0 = {L_B{10'd1023}}; b_ref1 = '0; b_in_frac = 6'd63; b_in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
    end
    #1;
    checks++;
    if (b_out_valid !== 1'b1 || b_out_pred !== {L_B{10'd16}}) begin
      errors++; $display("FAIL sweep_directed: valid %b pred %h expected 1 %h", b_out_valid, b_out_pred, {L_B{10'd16}});
    end
    expb_q.delete();
    for (int cyc = 0; cyc < n + 20; cyc++) begin
      @(negedge clk);
      b_in_valid  = (cyc < n) && ($urandom_range(0, 3) != 0);
      b_out_ready = (cyc >= n) || ($urandom_range(0, 1) == 1);
      rand_b();
      #1;
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (expb_q.size() == 0) begin
          errors++; $display("FAIL sweep_extra: unexpected beat %h", b_out_pred);
        end else begin
          e = expb_q.pop_front();
          if ({b_out_last, b_out_pred} !== e) begin
            errors++; $display("FAIL sweep_data: got %h expected %h", {b_out_last, b_out_pred}, e);
          end
        end
      end
      if (b_in_valid && b_in_ready) expb_q.push_back(model_b(b_in_last, b_ref0, b_ref1, b_in_frac));
    end
    checks++;
    if (expb_q.size() != 0) begin
      errors++; $display("FAIL sweep_drop: %0d beats missing expected 0", expb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single(8'd100, 8'd200, 5'd8,  8'd125);
    test_single(8'd100, 8'd200, 5'd0,  8'd100);
    test_single(8'd100, 8'd200, 5'd16, 8'd150);
    test_single(8'd0,   8'd255, 5'd31, 8'd247);
    test_single(8'd255, 8'd0,   5'd1,  8'd247);
    for (int i = 0; i < 4; i++) test_single(8'd255, 8'd255, 5'($urandom()), 8'd255);
    test_streaming();
    test_backpressure();
    test_random_a(2000);
    test_reset_mid();
    test_sweep(500);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
